// File: rtl/fetch_decode_ctrl_if.sv
// Control bundle between the fetch/decode pipeline and its sequencer.
// slave: the sequencer (status in, controls out); master: the pipeline.
interface fetch_decode_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic             i_ready;
    logic             m_busy;
    logic             exc;
    logic             x_branch_taken;
    logic             x_mem_read;
    logic [REG_W-1:0] x_rd;
    logic [REG_W-1:0] d_rs;
    logic [REG_W-1:0] d_rt;
    logic             d_uses_rs;
    logic             d_uses_rt;
    logic [1:0]       pc_sel;
    logic             f_stall;
    logic             fd_hold;
    logic             fd_flush;
    logic             dx_flush;
    logic             pipe_hold;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output i_ready, m_busy, exc, x_branch_taken, x_mem_read,
        output x_rd, d_rs, d_rt, d_uses_rs, d_uses_rt,
        input  pc_sel, f_stall, fd_hold, fd_flush, dx_flush,
        input  pipe_hold, state, stall_cnt
    );

    modport slave (
        input  i_ready, m_busy, exc, x_branch_taken, x_mem_read,
        input  x_rd, d_rs, d_rt, d_uses_rs, d_uses_rt,
        output pc_sel, f_stall, fd_hold, fd_flush, dx_flush,
        output pipe_hold, state, stall_cnt
    );
endinterface

// File: rtl/fetch_decode_ctrl.sv
// Fetch / F-D sequencer: PC select, stall, hold and flush controls.
// Ports: clock, reset (async active-low), bus (slave modport).
module fetch_decode_ctrl #(
    parameter int REG_W   = 5,
    parameter int BUBBLES = 1,
    parameter int CNT_W   = 16
) (
    input logic               clock,
    input logic               reset,
    fetch_decode_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEMWAIT  = 2'd1,
        REDIRECT = 2'd2,
        IMISS    = 2'd3
    } state_e;

    localparam logic [2:0] BUB = 3'(BUBBLES);

    state_e           state_q, state_d;
    logic [2:0]       bub_q, bub_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       load_use;
    logic       miss_wait;
    state_e     redir_st;
    logic [1:0] pc_sel;
    logic       f_stall, fd_hold, fd_flush, dx_flush, pipe_hold;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            bub_q   <= 3'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bub_q   <= bub_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        pc_sel    = 2'b00;
        f_stall   = 1'b0;
        fd_hold   = 1'b0;
        fd_flush  = 1'b0;
        dx_flush  = 1'b0;
        pipe_hold = 1'b0;
        state_d   = state_q;
        bub_d     = bub_q;
        miss_wait = 1'b0;
        redir_st  = (BUB != 3'd0) ? REDIRECT : RUN;
        load_use  = bus.x_mem_read && (bus.x_rd != '0) &&
                    ((bus.d_uses_rs && (bus.d_rs == bus.x_rd)) ||
                     (bus.d_uses_rt && (bus.d_rt == bus.x_rd)));

        if (bus.exc) begin
            pc_sel   = 2'b10;
            fd_flush = 1'b1;
            dx_flush = 1'b1;
            bub_d    = BUB;
            state_d  = redir_st;
        end else if (bus.m_busy) begin
            // Freeze everything; a pending branch is re-seen after busy drops.
            f_stall   = 1'b1;
            fd_hold   = 1'b1;
            pipe_hold = 1'b1;
            state_d   = MEMWAIT;
        end else if (bus.x_branch_taken) begin
            pc_sel   = 2'b01;
            fd_flush = 1'b1;
            dx_flush = 1'b1;
            bub_d    = BUB;
            state_d  = redir_st;
        end else if (state_q == REDIRECT) begin
            fd_flush = 1'b1;
            bub_d    = bub_q - 3'd1;
            if (bub_q <= 3'd1) begin
                bub_d   = 3'd0;
                state_d = bus.i_ready ? RUN : IMISS;
            end
        end else begin
            // RUN, released MEMWAIT, or IMISS: decode holds a bubble
            // while the miss persists, so no hazard check then.
            miss_wait = (state_q == IMISS) && !bus.i_ready;
            if (load_use && !miss_wait) begin
                f_stall  = 1'b1;
                fd_hold  = 1'b1;
                dx_flush = 1'b1;
                state_d  = RUN;
            end else if (!bus.i_ready) begin
                f_stall  = 1'b1;
                fd_flush = 1'b1;
                state_d  = IMISS;
            end else begin
                state_d = RUN;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (f_stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Reset holds fetch stalled and F/D bubbled regardless of inputs.
    always_comb begin
        if (!reset) begin
            bus.pc_sel    = 2'b00;
            bus.f_stall   = 1'b1;
            bus.fd_hold   = 1'b0;
            bus.fd_flush  = 1'b1;
            bus.dx_flush  = 1'b0;
            bus.pipe_hold = 1'b0;
        end else begin
            bus.pc_sel    = pc_sel;
            bus.f_stall   = f_stall;
            bus.fd_hold   = fd_hold;
            bus.fd_flush  = fd_flush;
            bus.dx_flush  = dx_flush;
            bus.pipe_hold = pipe_hold;
        end
    end

    assign bus.state     = state_q;
    assign bus.stall_cnt = cnt_q;
endmodule
